// File: rtl/move_step_counter.sv
// move_step_counter: prescaled, bounded playfield movement counter.
// A prescaler turns enabled cycles into step ticks. On each tick the position
// advances by STEP and, at a boundary, either bounces (MOVE_BOUNCE_EN defined)
// or wraps back to MIN (MOVE_BOUNCE_EN undefined, the default build).
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset
//   en_i        advance enable (frame tick or level)
//   load_i      synchronous load of load_val_i (clamped to MIN..MAX)
//   load_val_i  position to load
//   count_o     current position (registered)
//   dir_o       0 = increasing, 1 = decreasing (always 0 in wrap build)
//   step_o      one-cycle pulse in the cycle count_o took a step
//   edge_o      one-cycle pulse in the cycle a boundary was hit
module move_step_counter #(
    parameter int unsigned WIDTH    = 11,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned MIN      = 0,
    parameter int unsigned MAX      = 600,
    parameter int unsigned STEP     = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             dir_o,
    output logic             step_o,
    output logic             edge_o
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned XW = WIDTH + 1;

    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [XW-1:0]    MIN_X      = XW'(MIN);
    localparam logic [XW-1:0]    MAX_X      = XW'(MAX);
    localparam logic [XW-1:0]    STEP_X     = XW'(STEP);
    localparam logic [WIDTH-1:0] MIN_W      = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX);

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             step_q,  step_d;
    logic             edge_q,  edge_d;
`ifdef MOVE_BOUNCE_EN
    logic             dir_q,   dir_d;
    localparam logic [XW-1:0] LOW_X = XW'(MIN + STEP);
`endif

    logic             tick_c;
    logic [XW-1:0]    count_x_c;
    logic [XW-1:0]    sum_c;
    logic [XW-1:0]    load_x_c;

    // All bound checks are done one bit wider so nothing wraps silently.
    assign tick_c    = en_i && (presc_q == PRESC_LAST);
    assign count_x_c = {1'b0, count_q};
    assign sum_c     = count_x_c + STEP_X;
    assign load_x_c  = {1'b0, load_val_i};

    // Next-state: load > tick > prescale > hold.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        step_d  = 1'b0;
        edge_d  = 1'b0;
`ifdef MOVE_BOUNCE_EN
        dir_d   = dir_q;
`endif
        if (load_i) begin
            presc_d = '0;
            if (load_x_c < MIN_X) begin
                count_d = MIN_W;
            end else if (load_x_c > MAX_X) begin
                count_d = MAX_W;
            end else begin
                count_d = load_val_i;
            end
`ifdef MOVE_BOUNCE_EN
            dir_d   = 1'b0;
`endif
        end else if (tick_c) begin
            presc_d = '0;
            step_d  = 1'b1;
`ifdef MOVE_BOUNCE_EN
            if (!dir_q) begin
                if (sum_c <= MAX_X) begin
                    count_d = sum_c[WIDTH-1:0];
                end else begin
                    count_d = MAX_W;
                    dir_d   = 1'b1;
                    edge_d  = 1'b1;
                end
            end else begin
                if (count_x_c >= LOW_X) begin
                    count_d = count_q - WIDTH'(STEP);
                end else begin
                    count_d = MIN_W;
                    dir_d   = 1'b0;
                    edge_d  = 1'b1;
                end
            end
`else
            if (sum_c <= MAX_X) begin
                count_d = sum_c[WIDTH-1:0];
            end else begin
                count_d = MIN_W;
                edge_d  = 1'b1;
            end
`endif
        end else if (en_i) begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            count_q <= MIN_W;
            step_q  <= 1'b0;
            edge_q  <= 1'b0;
`ifdef MOVE_BOUNCE_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            step_q  <= step_d;
            edge_q  <= edge_d;
`ifdef MOVE_BOUNCE_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign count_o = count_q;
    assign step_o  = step_q;
    assign edge_o  = edge_q;
`ifdef MOVE_BOUNCE_EN
    assign dir_o   = dir_q;
`else
    assign dir_o   = 1'b0;
`endif

endmodule
